// File: rtl/axis_fifo_status_pkg.sv
// Shared types and width helpers for the AXIS FIFO status monitor.
package axis_fifo_status_pkg;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_t;

  localparam int DEPTH_DEFAULT   = 256;
  localparam int COUNT_W_DEFAULT = 32;

  // Occupancy fields must represent 0..DEPTH inclusive.
  function automatic int depth_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int count_w(input int count_width);
    return (count_width < 1) ? 1 : count_width;
  endfunction

endpackage

// File: rtl/axis_sat_counter.sv
// Saturating event counter; a clear keeps a coincident event as a count of one.
module axis_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= WIDTH'(inc);
    end else if (inc && (q != {WIDTH{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/axis_fifo_status_monitor.sv
// FIFO status statistics: saturating event counts, peak watermarks,
// hysteretic almost-full alarm and an atomic valid/ready snapshot.
module axis_fifo_status_monitor
  import axis_fifo_status_pkg::*;
#(
  parameter  int DEPTH       = DEPTH_DEFAULT,
  parameter  int COUNT_WIDTH = COUNT_W_DEFAULT,
  parameter  int HIGH_THRESH = 192,
  parameter  int LOW_THRESH  = 64,
  localparam int DW          = depth_w(DEPTH),
  localparam int CW          = count_w(COUNT_WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] depth,
  input  logic [DW-1:0] depth_commit,
  input  logic          overflow,
  input  logic          bad_frame,
  input  logic          good_frame,
  input  logic          snap_req,
  input  logic          snap_clear,
  output logic          snap_valid,
  input  logic          snap_ready,
  output logic [CW-1:0] snap_good,
  output logic [CW-1:0] snap_bad,
  output logic [CW-1:0] snap_ovf,
  output logic [DW-1:0] snap_peak,
  output logic [DW-1:0] snap_peak_commit,
  output logic          ovf_sticky,
  output logic          depth_alarm
);

  localparam logic [DW-1:0] HIGH_D = DW'(HIGH_THRESH);
  localparam logic [DW-1:0] LOW_D  = DW'(LOW_THRESH);

  snap_state_t   state, state_nxt;
  logic          capture;
  logic          clr_live;
  logic [CW-1:0] good_cnt, bad_cnt, ovf_cnt;
  logic [DW-1:0] peak, peak_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SNAP_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      SNAP_IDLE: begin
        if (snap_req) begin
          capture   = 1'b1;
          state_nxt = SNAP_HOLD;
        end
      end
      SNAP_HOLD: begin
        if (snap_ready) state_nxt = SNAP_IDLE;
      end
      default: state_nxt = SNAP_IDLE;
    endcase
  end

  assign clr_live   = capture & snap_clear;
  assign snap_valid = (state == SNAP_HOLD);

  axis_sat_counter #(.WIDTH(CW)) u_good_cnt (
    .clk(clk), .rst_n(rst_n), .inc(good_frame), .clr(clr_live), .q(good_cnt)
  );

  axis_sat_counter #(.WIDTH(CW)) u_bad_cnt (
    .clk(clk), .rst_n(rst_n), .inc(bad_frame), .clr(clr_live), .q(bad_cnt)
  );

  axis_sat_counter #(.WIDTH(CW)) u_ovf_cnt (
    .clk(clk), .rst_n(rst_n), .inc(overflow), .clr(clr_live), .q(ovf_cnt)
  );

  // A clear restarts the watermarks from the occupancy seen on the clearing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak        <= '0;
      peak_commit <= '0;
    end else if (clr_live) begin
      peak        <= depth;
      peak_commit <= depth_commit;
    end else begin
      if (depth > peak)               peak        <= depth;
      if (depth_commit > peak_commit) peak_commit <= depth_commit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_alarm <= 1'b0;
    end else if (depth >= HIGH_D) begin
      depth_alarm <= 1'b1;
    end else if (depth <= LOW_D) begin
      depth_alarm <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (clr_live) begin
      ovf_sticky <= overflow;
    end else if (overflow) begin
      ovf_sticky <= 1'b1;
    end
  end

  // Snapshot takes the pre-edge live values, so it is coherent across all fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_good        <= '0;
      snap_bad         <= '0;
      snap_ovf         <= '0;
      snap_peak        <= '0;
      snap_peak_commit <= '0;
    end else if (capture) begin
      snap_good        <= good_cnt;
      snap_bad         <= bad_cnt;
      snap_ovf         <= ovf_cnt;
      snap_peak        <= peak;
      snap_peak_commit <= peak_commit;
    end
  end

endmodule

// File: tb/tb_axis_fifo_status_monitor.sv
// Directed bench: expected snapshots are queued at request time and checked
// by an independent monitor on each valid/ready handshake.
module tb_axis_fifo_status_monitor;

  localparam int DEPTH = 16;
  localparam int CW    = 4;
  localparam int HI    = 12;
  localparam int LO    = 4;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] depth, depth_commit;
  logic          overflow, bad_frame, good_frame;
  logic          snap_req, snap_clear, snap_ready;
  logic          snap_valid;
  logic [CW-1:0] snap_good, snap_bad, snap_ovf;
  logic [DW-1:0] snap_peak, snap_peak_commit;
  logic          ovf_sticky, depth_alarm;

  typedef struct {
    int good;
    int bad;
    int ovf;
    int peak;
    int peakc;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e;
  int    errors = 0;
  int    checks = 0;

  axis_fifo_status_monitor #(
    .DEPTH(DEPTH), .COUNT_WIDTH(CW), .HIGH_THRESH(HI), .LOW_THRESH(LO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .depth(depth), .depth_commit(depth_commit),
    .overflow(overflow), .bad_frame(bad_frame), .good_frame(good_frame),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_valid(snap_valid),
    .snap_ready(snap_ready), .snap_good(snap_good), .snap_bad(snap_bad),
    .snap_ovf(snap_ovf), .snap_peak(snap_peak), .snap_peak_commit(snap_peak_commit),
    .ovf_sticky(ovf_sticky), .depth_alarm(depth_alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && snap_valid && snap_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_snapshot", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("snap_good",        32'(snap_good),        mon_e.good);
        chk("snap_bad",         32'(snap_bad),         mon_e.bad);
        chk("snap_ovf",         32'(snap_ovf),         mon_e.ovf);
        chk("snap_peak",        32'(snap_peak),        mon_e.peak);
        chk("snap_peak_commit", 32'(snap_peak_commit), mon_e.peakc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input int b, input int o, input int p, input int pc);
    snap_t s;
    s.good = g; s.bad = b; s.ovf = o; s.peak = p; s.peakc = pc;
    exp_q.push_back(s);
  endtask

  task automatic pulses(input int n, input logic g, input logic b, input logic o);
    good_frame = g; bad_frame = b; overflow = o;
    repeat (n) tick();
    good_frame = 1'b0; bad_frame = 1'b0; overflow = 1'b0;
  endtask

  task automatic req_snap(input logic clr, input logic g, input logic b, input logic o);
    snap_req = 1'b1; snap_clear = clr;
    good_frame = g; bad_frame = b; overflow = o;
    tick();
    snap_req = 1'b0; snap_clear = 1'b0;
    good_frame = 1'b0; bad_frame = 1'b0; overflow = 1'b0;
    chk("snap_valid_rise", 32'(snap_valid), 32'd1);
  endtask

  task automatic accept();
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    chk("snap_valid_fall", 32'(snap_valid), 32'd0);
  endtask

  task automatic snap(input logic clr, input logic g, input logic b, input logic o,
                      input int eg, input int eb, input int eo, input int ep, input int epc);
    push(eg, eb, eo, ep, epc);
    req_snap(clr, g, b, o);
    accept();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    depth = '0; depth_commit = '0;
    overflow = 1'b0; bad_frame = 1'b0; good_frame = 1'b0;
    snap_req = 1'b0; snap_clear = 1'b0; snap_ready = 1'b0;
    repeat (2) tick();
    chk("rst_snap_valid",  32'(snap_valid),  32'd0);
    chk("rst_snap_good",   32'(snap_good),   32'd0);
    chk("rst_ovf_sticky",  32'(ovf_sticky),  32'd0);
    chk("rst_depth_alarm", 32'(depth_alarm), 32'd0);
    rst_n = 1'b1;
    tick();

    // Saturation of the good counter
    pulses(20, 1'b1, 1'b0, 1'b0);
    snap(1'b1, 1'b0, 1'b0, 1'b0, 15, 0, 0, 0, 0);

    // Alarm hysteresis 0 -> 12 -> 8 -> 5 -> 4 -> 13
    chk("alarm_idle", 32'(depth_alarm), 32'd0);
    depth = 5'd12;
    chk("alarm_latency", 32'(depth_alarm), 32'd0);
    tick(); chk("alarm_set_12",  32'(depth_alarm), 32'd1);
    depth = 5'd8;  tick(); chk("alarm_hold_8", 32'(depth_alarm), 32'd1);
    depth = 5'd5;  tick(); chk("alarm_hold_5", 32'(depth_alarm), 32'd1);
    depth = 5'd4;  tick(); chk("alarm_clr_4",  32'(depth_alarm), 32'd0);
    depth = 5'd13; tick(); chk("alarm_set_13", 32'(depth_alarm), 32'd1);
    depth = 5'd0;  tick(); chk("alarm_clr_0",  32'(depth_alarm), 32'd0);
    snap(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 13, 0);

    // Clear with a coincident good_frame keeps that event
    pulses(7, 1'b1, 1'b0, 1'b0);
    snap(1'b1, 1'b1, 1'b0, 1'b0, 7, 0, 0, 0, 0);
    snap(1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0);

    // Handshake stall with events and a second request during HOLD
    pulses(2, 1'b0, 1'b0, 1'b1);
    pulses(1, 1'b0, 1'b1, 1'b0);
    chk("ovf_sticky_set", 32'(ovf_sticky), 32'd1);
    push(0, 1, 2, 0, 0);
    req_snap(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bad_frame  = (i < 3);
      snap_req   = (i == 5);
      snap_clear = (i == 5);
      tick();
      chk("hold_valid", 32'(snap_valid), 32'd1);
      chk("hold_bad",   32'(snap_bad),   32'd1);
    end
    bad_frame = 1'b0; snap_req = 1'b0; snap_clear = 1'b0;
    accept();
    chk("ovf_sticky_kept", 32'(ovf_sticky), 32'd1);
    snap(1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 2, 0, 0);
    chk("ovf_sticky_cleared", 32'(ovf_sticky), 32'd0);

    // Peak watermarks and simultaneous pulses
    depth = 5'd3; depth_commit = 5'd1; tick();
    depth = 5'd9; depth_commit = 5'd6; tick();
    depth = 5'd2; depth_commit = 5'd2; tick();
    snap(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 9, 6);
    pulses(1, 1'b1, 1'b1, 1'b1);
    snap(1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 2, 2);

    // Saturated counter cleared with an event on the same edge
    pulses(18, 1'b0, 1'b1, 1'b0);
    snap(1'b1, 1'b0, 1'b1, 1'b0, 0, 15, 0, 2, 2);
    snap(1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 2, 2);

    // Asynchronous reset while holding a snapshot
    pulses(1, 1'b0, 1'b0, 1'b1);
    depth = 5'd13;
    tick();
    chk("pre_rst_alarm",  32'(depth_alarm), 32'd1);
    chk("pre_rst_sticky", 32'(ovf_sticky),  32'd1);
    req_snap(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_snap_ovf", 32'(snap_ovf), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid",      32'(snap_valid),       32'd0);
    chk("async_rst_good",       32'(snap_good),        32'd0);
    chk("async_rst_bad",        32'(snap_bad),         32'd0);
    chk("async_rst_ovf",        32'(snap_ovf),         32'd0);
    chk("async_rst_peak",       32'(snap_peak),        32'd0);
    chk("async_rst_peak_commit",32'(snap_peak_commit), 32'd0);
    chk("async_rst_sticky",     32'(ovf_sticky),       32'd0);
    chk("async_rst_alarm",      32'(depth_alarm),      32'd0);
    depth = '0; depth_commit = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(snap_valid), 32'd0);
    snap(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
